// File: rtl/mem_sched.sv
// Round-robin byte-serial scheduler sharing one 8-bit memory port among fetch, load and store.
// Optional build macro IO_BUF_STALL_EN: stalls stores to the UART window while its buffer is full.
module mem_sched #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              lr_req_in,
  input  logic [ADDR_W-1:0] lr_addr_in,
  input  logic [1:0]        lr_len_in,
  output logic              lr_done_out,
  output logic [31:0]       lr_data_out,
  input  logic              lw_req_in,
  input  logic [ADDR_W-1:0] lw_addr_in,
  input  logic [1:0]        lw_len_in,
  input  logic [31:0]       lw_data_in,
  output logic              lw_done_out,
  input  logic              io_buffer_full_in,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic [7:0]        mem_dout,
  output logic              mem_wr_out
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {G_IF = 2'd0, G_LR = 2'd1, G_LW = 2'd2} gnt_t;

  state_t            state, state_d;
  gnt_t              gnt, gnt_d;
  logic [1:0]        last, last_d;
  logic [2:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] mem_a_d;
  logic [7:0]        mem_dout_d;
  logic              mem_wr_d;
  logic              if_done_d, lr_done_d, lw_done_d;
  logic [31:0]       if_data_d, lr_data_d;
  logic [31:0]       rd_buf, rd_buf_d;

  logic [2:0]        cur_len;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        elig;
  logic [2:0]        pick;
  logic              stall;
  logic              abort;

  // Returns {found, index}; search order is last+1, last+2, last.
  function automatic logic [2:0] rr_pick(input logic [1:0] last_g, input logic [2:0] req);
    logic [1:0] o0, o1, o2;
    case (last_g)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (req[o0])      return {1'b1, o0};
    else if (req[o1]) return {1'b1, o1};
    else if (req[o2]) return {1'b1, o2};
    return 3'b000;
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

`ifdef IO_BUF_STALL_EN
  assign stall = (lw_addr_in[17:16] == 2'b11) && io_buffer_full_in;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full_in;
  assign stall = 1'b0;
`endif

  always_comb begin
    cur_len  = {1'b0, lw_len_in};
    cur_addr = lw_addr_in;
    case (gnt)
      G_IF:    begin cur_len = 3'd3;             cur_addr = if_addr_in; end
      G_LR:    begin cur_len = {1'b0, lr_len_in}; cur_addr = lr_addr_in; end
      default: begin cur_len = {1'b0, lw_len_in}; cur_addr = lw_addr_in; end
    endcase
  end

  // The requester finishing in DONE still holds req that edge, so it sits out one arbitration.
  always_comb begin
    elig = {lw_req_in, lr_req_in, if_req_in};
    if (clear_in) elig[1:0] = 2'b00;
    if (state == S_DONE) begin
      case (gnt)
        G_IF:    elig[0] = 1'b0;
        G_LR:    elig[1] = 1'b0;
        default: elig[2] = 1'b0;
      endcase
    end
    pick  = rr_pick(last, elig);
    abort = clear_in && (gnt != G_LW);
  end

  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    last_d     = last;
    cnt_d      = cnt;
    mem_a_d    = '0;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;
    if_done_d  = 1'b0;
    lr_done_d  = 1'b0;
    lw_done_d  = 1'b0;
    if_data_d  = if_data_out;
    lr_data_d  = lr_data_out;
    rd_buf_d   = rd_buf;
    case (state)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        if (!(state == S_DONE && abort) && pick[2]) begin
          gnt_d  = gnt_t'(pick[1:0]);
          last_d = pick[1:0];
          if (pick[1:0] == G_LW) begin
            state_d = S_WRITE;
            if (!stall) begin
              mem_a_d    = lw_addr_in;
              mem_dout_d = lw_data_in[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d  = S_READ;
            mem_a_d  = (pick[1:0] == G_IF) ? if_addr_in : lr_addr_in;
            cnt_d    = 3'd1;
            rd_buf_d = '0;
          end
        end
      end
      S_WRITE: begin
        if (cnt <= cur_len) begin
          if (!stall) begin
            mem_a_d    = cur_addr + ADDR_W'(cnt);
            mem_dout_d = lw_data_in[{cnt[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            cnt_d      = cnt + 3'd1;
          end
        end else begin
          state_d   = S_DONE;
          lw_done_d = 1'b1;
        end
      end
      S_READ: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          // cnt is the edge index: issue byte cnt, capture byte cnt-2.
          if (cnt <= cur_len) mem_a_d = cur_addr + ADDR_W'(cnt);
          if (cnt >= 3'd2) rd_buf_d = merge_byte(rd_buf, cnt[1:0] - 2'd2, mem_din);
          if (cnt == cur_len + 3'd2) begin
            state_d = S_DONE;
            if (gnt == G_IF) begin
              if_done_d = 1'b1;
              if_data_d = rd_buf_d;
            end else begin
              lr_done_d = 1'b1;
              lr_data_d = rd_buf_d;
            end
          end
          cnt_d = cnt + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= S_IDLE;
      gnt         <= G_IF;
      last        <= 2'd2;
      cnt         <= 3'd0;
      mem_a_out   <= '0;
      mem_dout    <= '0;
      mem_wr_out  <= 1'b0;
      if_done_out <= 1'b0;
      lr_done_out <= 1'b0;
      lw_done_out <= 1'b0;
      if_data_out <= '0;
      lr_data_out <= '0;
    end else if (rdy_in) begin
      state       <= state_d;
      gnt         <= gnt_d;
      last        <= last_d;
      cnt         <= cnt_d;
      mem_a_out   <= mem_a_d;
      mem_dout    <= mem_dout_d;
      mem_wr_out  <= mem_wr_d;
      if_done_out <= if_done_d;
      lr_done_out <= lr_done_d;
      lw_done_out <= lw_done_d;
      if_data_out <= if_data_d;
      lr_data_out <= lr_data_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) rd_buf <= rd_buf_d;
  end

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched with a small byte RAM model answering one cycle after the address.
module tb_mem_sched;
  localparam int ADDR_W = 32;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, clear_in;
  logic              if_req_in, if_done_out;
  logic [ADDR_W-1:0] if_addr_in;
  logic [31:0]       if_data_out;
  logic              lr_req_in, lr_done_out;
  logic [ADDR_W-1:0] lr_addr_in;
  logic [1:0]        lr_len_in;
  logic [31:0]       lr_data_out;
  logic              lw_req_in, lw_done_out;
  logic [ADDR_W-1:0] lw_addr_in;
  logic [1:0]        lw_len_in;
  logic [31:0]       lw_data_in;
  logic              io_buffer_full_in;
  logic [7:0]        mem_din;
  logic [ADDR_W-1:0] mem_a_out;
  logic [7:0]        mem_dout;
  logic              mem_wr_out;

  logic [7:0]  ram [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = '0;
  logic [7:0]  pre_d = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a_out[15:0]];
    if (mem_wr_out) ram[mem_a_out[15:0]] <= mem_dout;
    if (pre_we) ram[pre_a] <= pre_d;
  end

  mem_sched #(.ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
    .if_data_out(if_data_out),
    .lr_req_in(lr_req_in), .lr_addr_in(lr_addr_in), .lr_len_in(lr_len_in),
    .lr_done_out(lr_done_out), .lr_data_out(lr_data_out),
    .lw_req_in(lw_req_in), .lw_addr_in(lw_addr_in), .lw_len_in(lw_len_in),
    .lw_data_in(lw_data_in), .lw_done_out(lw_done_out),
    .io_buffer_full_in(io_buffer_full_in), .mem_din(mem_din),
    .mem_a_out(mem_a_out), .mem_dout(mem_dout), .mem_wr_out(mem_wr_out)
  );

  task automatic idle_inputs();
    rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = '0;
    lr_req_in = 1'b0; lr_addr_in = '0; lr_len_in = '0;
    lw_req_in = 1'b0; lw_addr_in = '0; lw_len_in = '0; lw_data_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk_in); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    n_cmp++; if (if_done_out !== 1'b0) begin n_fail++; $display("FAIL rst_if_done got %b want 0", if_done_out); end
    n_cmp++; if (lr_done_out !== 1'b0) begin n_fail++; $display("FAIL rst_lr_done got %b want 0", lr_done_out); end
    n_cmp++; if (lw_done_out !== 1'b0) begin n_fail++; $display("FAIL rst_lw_done got %b want 0", lw_done_out); end
    n_cmp++; if (mem_wr_out !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr got %b want 0", mem_wr_out); end
    n_cmp++; if (mem_a_out !== 32'h0) begin n_fail++; $display("FAIL rst_mem_a got %h want 0", mem_a_out); end
    n_cmp++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL rst_mem_dout got %h want 0", mem_dout); end
    n_cmp++; if (if_data_out !== 32'h0) begin n_fail++; $display("FAIL rst_if_data got %h want 0", if_data_out); end
    n_cmp++; if (lr_data_out !== 32'h0) begin n_fail++; $display("FAIL rst_lr_data got %h want 0", lr_data_out); end
  endtask

  task automatic test_fetch();
    logic [31:0] ea;
    preload(16'h0100, 8'h13); preload(16'h0101, 8'h05);
    preload(16'h0102, 8'h00); preload(16'h0103, 8'h00);
    do_reset();
    if_req_in = 1'b1; if_addr_in = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk_in); #1;
      ea = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
      if (c <= 5) begin
        n_cmp++; if (mem_a_out !== ea) begin n_fail++; $display("FAIL fetch_addr c%0d got %h want %h", c, mem_a_out, ea); end
        n_cmp++; if (mem_wr_out !== 1'b0) begin n_fail++; $display("FAIL fetch_wr c%0d got %b want 0", c, mem_wr_out); end
      end
      n_cmp++; if (if_done_out !== (c == 6)) begin n_fail++; $display("FAIL fetch_done c%0d got %b want %b", c, if_done_out, (c == 6)); end
      if (c >= 6) begin
        n_cmp++; if (if_data_out !== 32'h0000_0513) begin n_fail++; $display("FAIL fetch_data c%0d got %h want 00000513", c, if_data_out); end
      end
      if (c == 6) if_req_in = 1'b0;
    end
  endtask

  task automatic test_store_load();
    logic [31:0] ea;
    do_reset();
    lw_req_in = 1'b1; lw_addr_in = 32'h2000; lw_len_in = 2'd1; lw_data_in = 32'h0000_ABCD;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk_in); #1;
      ea = (c <= 2) ? 32'h2000 + 32'(c - 1) : 32'h0;
      n_cmp++; if (mem_a_out !== ea) begin n_fail++; $display("FAIL store_addr c%0d got %h want %h", c, mem_a_out, ea); end
      n_cmp++; if (mem_wr_out !== (c <= 2)) begin n_fail++; $display("FAIL store_wr c%0d got %b want %b", c, mem_wr_out, (c <= 2)); end
      n_cmp++; if (lw_done_out !== (c == 3)) begin n_fail++; $display("FAIL store_done c%0d got %b want %b", c, lw_done_out, (c == 3)); end
      if (c == 1) begin
        n_cmp++; if (mem_dout !== 8'hCD) begin n_fail++; $display("FAIL store_b0 got %h want cd", mem_dout); end
      end
      if (c == 2) begin
        n_cmp++; if (mem_dout !== 8'hAB) begin n_fail++; $display("FAIL store_b1 got %h want ab", mem_dout); end
      end
    end
    lw_req_in = 1'b0;
    @(posedge clk_in); #1;
    n_cmp++; if (ram[16'h2000] !== 8'hCD) begin n_fail++; $display("FAIL ram_2000 got %h want cd", ram[16'h2000]); end
    n_cmp++; if (ram[16'h2001] !== 8'hAB) begin n_fail++; $display("FAIL ram_2001 got %h want ab", ram[16'h2001]); end
    lr_req_in = 1'b1; lr_addr_in = 32'h2000; lr_len_in = 2'd1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_in); #1;
      if (c <= 2) begin
        ea = 32'h2000 + 32'(c - 1);
        n_cmp++; if (mem_a_out !== ea) begin n_fail++; $display("FAIL load_addr c%0d got %h want %h", c, mem_a_out, ea); end
      end
      n_cmp++; if (lr_done_out !== (c == 4)) begin n_fail++; $display("FAIL load_done c%0d got %b want %b", c, lr_done_out, (c == 4)); end
      if (c == 4) begin
        n_cmp++; if (lr_data_out !== 32'h0000_ABCD) begin n_fail++; $display("FAIL load_data got %h want 0000abcd", lr_data_out); end
        lr_req_in = 1'b0;
      end
    end
  endtask

  task automatic test_fairness();
    int ev_who [4];
    int ev_cyc [4];
    int n_ev;
    int nd;
    int exp_who [4];
    int exp_cyc [4];
    exp_who = '{0, 1, 2, 0};
    exp_cyc = '{6, 10, 12, 18};
    n_ev = 0;
    do_reset();
    if_req_in = 1'b1; if_addr_in = 32'h100;
    lr_req_in = 1'b1; lr_addr_in = 32'h2000; lr_len_in = 2'd1;
    lw_req_in = 1'b1; lw_addr_in = 32'h3000; lw_len_in = 2'd0; lw_data_in = 32'h5A;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk_in); #1;
      nd = int'(if_done_out) + int'(lr_done_out) + int'(lw_done_out);
      n_cmp++; if (nd > 1) begin n_fail++; $display("FAIL fair_overlap c%0d got %0d dones want <=1", c, nd); end
      if (nd == 1 && n_ev < 4) begin
        ev_who[n_ev] = if_done_out ? 0 : (lr_done_out ? 1 : 2);
        ev_cyc[n_ev] = c;
        n_ev++;
      end
      if (c == 18) begin if_req_in = 1'b0; lr_req_in = 1'b0; lw_req_in = 1'b0; end
    end
    n_cmp++; if (n_ev !== 4) begin n_fail++; $display("FAIL fair_count got %0d want 4", n_ev); end
    for (int i = 0; i < 4; i++) begin
      if (i < n_ev) begin
        n_cmp++; if (ev_who[i] !== exp_who[i]) begin n_fail++; $display("FAIL fair_who%0d got %0d want %0d", i, ev_who[i], exp_who[i]); end
        n_cmp++; if (ev_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL fair_cyc%0d got %0d want %0d", i, ev_cyc[i], exp_cyc[i]); end
      end
    end
    n_cmp++; if (mem_a_out !== 32'h0) begin n_fail++; $display("FAIL fair_idle_addr got %h want 0", mem_a_out); end
  endtask

  task automatic test_clear_read();
    logic [31:0] ea;
    do_reset();
    lr_req_in = 1'b1; lr_addr_in = 32'h100; lr_len_in = 2'd3;
    lw_req_in = 1'b1; lw_addr_in = 32'h2100; lw_len_in = 2'd0; lw_data_in = 32'h77;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk_in); #1;
      n_cmp++; if (lr_done_out !== 1'b0) begin n_fail++; $display("FAIL clr_rd_done c%0d got %b want 0", c, lr_done_out); end
      if (c <= 3) begin
        ea = 32'h100 + 32'(c - 1);
        n_cmp++; if (mem_a_out !== ea) begin n_fail++; $display("FAIL clr_rd_addr c%0d got %h want %h", c, mem_a_out, ea); end
      end
      if (c == 4) begin
        n_cmp++; if (mem_a_out !== 32'h0) begin n_fail++; $display("FAIL clr_rd_port got %h want 0", mem_a_out); end
        clear_in = 1'b0;
      end
      if (c == 5) begin
        n_cmp++; if (mem_wr_out !== 1'b1) begin n_fail++; $display("FAIL clr_rd_lw_wr got %b want 1", mem_wr_out); end
        n_cmp++; if (mem_a_out !== 32'h2100) begin n_fail++; $display("FAIL clr_rd_lw_addr got %h want 2100", mem_a_out); end
        n_cmp++; if (mem_dout !== 8'h77) begin n_fail++; $display("FAIL clr_rd_lw_data got %h want 77", mem_dout); end
      end
      if (c == 6) begin
        n_cmp++; if (lw_done_out !== 1'b1) begin n_fail++; $display("FAIL clr_rd_lw_done got %b want 1", lw_done_out); end
        lw_req_in = 1'b0;
      end
      if (c == 3) begin clear_in = 1'b1; lr_req_in = 1'b0; end
    end
    n_cmp++; if (lr_data_out !== 32'h0) begin n_fail++; $display("FAIL clr_rd_stale got %h want 0", lr_data_out); end
  endtask

  task automatic test_clear_write();
    logic [31:0] ea;
    logic [7:0]  ed;
    do_reset();
    lw_req_in = 1'b1; lw_addr_in = 32'h2200; lw_len_in = 2'd3; lw_data_in = 32'h1122_3344;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_in); #1;
      ea = (c <= 4) ? 32'h2200 + 32'(c - 1) : 32'h0;
      ed = (c == 1) ? 8'h44 : (c == 2) ? 8'h33 : (c == 3) ? 8'h22 : (c == 4) ? 8'h11 : 8'h00;
      n_cmp++; if (mem_a_out !== ea) begin n_fail++; $display("FAIL clr_wr_addr c%0d got %h want %h", c, mem_a_out, ea); end
      n_cmp++; if (mem_dout !== ed) begin n_fail++; $display("FAIL clr_wr_data c%0d got %h want %h", c, mem_dout, ed); end
      n_cmp++; if (mem_wr_out !== (c <= 4)) begin n_fail++; $display("FAIL clr_wr_wr c%0d got %b want %b", c, mem_wr_out, (c <= 4)); end
      n_cmp++; if (lw_done_out !== (c == 5)) begin n_fail++; $display("FAIL clr_wr_done c%0d got %b want %b", c, lw_done_out, (c == 5)); end
      if (c == 2) clear_in = 1'b1;
      if (c == 3) clear_in = 1'b0;
      if (c == 5) lw_req_in = 1'b0;
    end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    lw_req_in = 1'b1; lw_addr_in = 32'h2300; lw_len_in = 2'd0; lw_data_in = 32'h5A;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_in); #1;
      if (c == 1) begin
        n_cmp++; if (mem_wr_out !== 1'b1) begin n_fail++; $display("FAIL rdy_wr got %b want 1", mem_wr_out); end
      end else begin
        n_cmp++; if (lw_done_out !== (c <= 4)) begin n_fail++; $display("FAIL rdy_done c%0d got %b want %b", c, lw_done_out, (c <= 4)); end
      end
      if (c == 2) rdy_in = 1'b0;
      if (c == 4) begin rdy_in = 1'b1; lw_req_in = 1'b0; end
    end
  endtask

`ifdef IO_BUF_STALL_EN
  task automatic test_io_stall();
    do_reset();
    lw_req_in = 1'b1; lw_addr_in = 32'h3_0000; lw_len_in = 2'd0; lw_data_in = 32'h99;
    io_buffer_full_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk_in); #1;
      n_cmp++; if (mem_wr_out !== (c == 4)) begin n_fail++; $display("FAIL stall_wr c%0d got %b want %b", c, mem_wr_out, (c == 4)); end
      n_cmp++; if (lw_done_out !== (c == 5)) begin n_fail++; $display("FAIL stall_done c%0d got %b want %b", c, lw_done_out, (c == 5)); end
      if (c <= 3) begin
        n_cmp++; if (mem_a_out !== 32'h0) begin n_fail++; $display("FAIL stall_addr c%0d got %h want 0", c, mem_a_out); end
      end
      if (c == 4) begin
        n_cmp++; if (mem_a_out !== 32'h3_0000) begin n_fail++; $display("FAIL stall_issue_addr got %h want 30000", mem_a_out); end
        n_cmp++; if (mem_dout !== 8'h99) begin n_fail++; $display("FAIL stall_issue_data got %h want 99", mem_dout); end
      end
      if (c == 3) io_buffer_full_in = 1'b0;
      if (c == 5) lw_req_in = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_fairness();
    test_clear_read();
    test_clear_write();
    test_rdy_freeze();
`ifdef IO_BUF_STALL_EN
    test_io_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
# mem_sched

Byte-serial memory scheduler between the CPU front end and the single 8-bit RAM/IO port. It shares the port among three requesters: instruction fetch (IF), LSB load, and LSB store. Sharing is round-robin. Each granted transfer is sequenced byte by byte, and the result is returned with a one-cycle done pulse. A pipeline clear aborts speculative reads, while stores always run to completion.

## Interface
- `ADDR_W`, default 32, is the width of every address.
- `clk_in`  in  1  is the clock.
- `rst_in`  in  1  is the reset: asynchronous, active-high.
- `rdy_in`  in  1  is the global enable. When it is low, all state holds.
- `clear_in`  in  1  is the pipeline flush caused by a misprediction.
- `if_req_in`  in  1  is the fetch request. It is always 4 bytes.
- `if_addr_in`  in  ADDR_W  is the fetch address.
- `if_done_out`  out  1  is the fetch-complete pulse.
- `if_data_out`  out  32  is the fetched word.
- `lr_req_in`  in  1  is the load request.
- `lr_addr_in`  in  ADDR_W  is the load address.
- `lr_len_in`  in  2  is the load length, encoded as byte count minus 1.
- `lr_done_out`  out  1  is the load-complete pulse.
- `lr_data_out`  out  32  is the load data, zero-extended.
- `lw_req_in`  in  1  is the store request.
- `lw_addr_in`  in  ADDR_W  is the store address.
- `lw_len_in`  in  2  is the store length, encoded as byte count minus 1.
- `lw_data_in`  in  32  is the store data.
- `lw_done_out`  out  1  is the store-complete pulse.
- `io_buffer_full_in`  in  1  is the UART buffer-full flag. It is used only under `IO_BUF_STALL_EN`.
- `mem_din`  in  8  is the read byte. It is valid the cycle after its address is driven.
- `mem_a_out`  out  ADDR_W  is the port address.
- `mem_dout`  out  8  is the port write byte.
- `mem_wr_out`  out  1  is the port write strobe.

## Operation
- FSM states are IDLE, READ, WRITE and DONE.
- The current grant is held in `gnt`, with values IF, LR and LW. The round-robin pointer `last` is 2 bits.
- **Reset:** all outputs are 0, the FSM is in IDLE, and `last`=LW, so IF has first priority.
- **Arbitration in IDLE:** requests are checked in the order `last`+1, `last`+2, `last`. The first active request is granted and `last` is set to the grantee.
- **Clear in IDLE:** when `clear_in` is high, IF and LR are ineligible for grant that edge.
- **Request contract:** a requester holds its req, addr, len and data stable from assertion until its done pulse. It drops req no later than the edge that ends the done cycle.
- **Byte ordering:** transfers are little-endian. Byte k uses address `addr`+k and data bits [8k+7:8k]. The byte count N is len+1, or 4 for IF. Addition wraps at `ADDR_W`.
- **READ (IF or LR):**
  - Issue addresses for bytes 0..N-1 on consecutive cycles.
  - Capture `mem_din` one cycle after each address into the output register. Bits above 8N read as 0.
  - After the last byte is captured, go to DONE.
- **WRITE:** drive address, data and `mem_wr_out`=1 for bytes 0..N-1 on consecutive cycles, then go to DONE.
- **DONE:** the matching done output is high for exactly one cycle, then the FSM returns to IDLE.
- **Idle port state:** outside active byte cycles, `mem_a_out`, `mem_dout` and `mem_wr_out` are 0.
- **Clear during READ or DONE of IF/LR:**
  - Abort at that edge and go to IDLE.
  - No done pulse is produced.
  - Port outputs go to 0.
  - The data register keeps its stale value.
- **Clear during WRITE or DONE of LW:** ignored. The store completes normally.
- **No overlap:** transfers never overlap, and at most one done output is high in any cycle.

## Timing
- Cycle numbering: the grant edge is edge 0, and cycle k is the cycle after edge k-1.
- **Read of N bytes:**
  - Address of byte k is driven in cycle k+1.
  - Its data is captured at edge k+2.
  - Done is high in cycle N+2.
  - A 4-byte fetch therefore has done in cycle 6.
- **Write of N bytes:** bytes are driven in cycles 1..N and done is high in cycle N+1.
- **Turnaround:** the earliest next grant is at the edge ending the done cycle. There are no idle bubbles beyond DONE.
- **Outputs:** all outputs are registered.
- **rdy_in low:** freezes the FSM, counters and outputs, including a done pulse, which stays high.

## Configuration
- **`IO_BUF_STALL_EN` defined:**
  - In WRITE, if `lw_addr_in[17:16]`==2'b11 and `io_buffer_full_in` is high, the current byte is not issued.
  - While stalled, `mem_wr_out`=0, `mem_a_out`=0, and the byte counter holds.
  - Issue resumes in the cycle after the flag drops.
- **`IO_BUF_STALL_EN` undefined:** `io_buffer_full_in` is ignored, and writes never stall.

## Test plan
- **Reset then fetch:** `if_req_in`=1, `if_addr_in`=0x100, RAM bytes 0x13,0x05,0x00,0x00 → addresses 0x100..0x103 in cycles 1..4; `if_done_out` in cycle 6; `if_data_out`=0x00000513.
- **Store:** `lw_req_in`=1, `lw_addr_in`=0x2000, len=1, data=0xABCD → writes 0xCD@0x2000 and 0xAB@0x2001 in cycles 1-2; `lw_done_out` in cycle 3; a subsequent 2-byte load of 0x2000 returns `lr_data_out`=0x0000ABCD.
- **Fairness:** with all three requests held continuously from reset, grant order is IF, LR, LW, IF, and each receives exactly one done per rotation.
- **Clear mid-read:** `clear_in` pulsed in cycle 3 of a 4-byte load → no `lr_done_out`, port returns to 0 by the next cycle, and a waiting store is granted next.
- **Clear mid-write:** `clear_in` during cycle 2 of a 4-byte store → all 4 bytes are written and `lw_done_out` appears in cycle 5.
- **IO stall (`IO_BUF_STALL_EN`):** 1-byte store to 0x30000 with `io_buffer_full_in` high for 3 cycles → `mem_wr_out` stays low during those cycles, then a single write of the byte; `lw_done_out` follows one cycle after the write.
